// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW SPI frame transmitter.
// Optional build macro RGBW_TX_CHECKSUM_EN appends an XOR checksum byte to each frame.
package rgbw_pkg;

  // Number of payload bytes latched from the inputs
  localparam int PAYLOAD_LEN = 7;

`ifdef RGBW_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 8;
`else
  localparam int FRAME_LEN = 7;
`endif

  // Position of each byte within the transmitted frame
  localparam logic [2:0] BYTE_MODE  = 3'd0;
  localparam logic [2:0] BYTE_LINT  = 3'd1;
  localparam logic [2:0] BYTE_COLOR = 3'd2;
  localparam logic [2:0] BYTE_RED   = 3'd3;
  localparam logic [2:0] BYTE_GREEN = 3'd4;
  localparam logic [2:0] BYTE_BLUE  = 3'd5;
  localparam logic [2:0] BYTE_WHITE = 3'd6;
  localparam logic [2:0] BYTE_CSUM  = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    FINISH
  } state_t;

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte shifter: sck half-period divider plus 8-bit MSB-first shift register.
// load presets the byte and drives its MSB; en runs the clock; byte_done flags the
// edge carrying the 16th (final, falling) sck transition.
module spi_byte_tx #(
  parameter int SCK_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic       byte_done,
  output logic       sck,
  output logic       mosi
);

  logic [7:0] phase;
  logic [3:0] half_cnt;
  logic [7:0] shreg;
  logic       half_tick;

  assign half_tick = en && (phase == 8'(SCK_HALF - 1));
  assign byte_done = half_tick && (half_cnt == 4'd15);

  // Divider, sck toggling and shift register; mosi moves only on falling sck or load
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      half_cnt <= '0;
      shreg    <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
    end else if (load) begin
      phase    <= '0;
      half_cnt <= '0;
      shreg    <= data;
      sck      <= 1'b0;
      mosi     <= data[7];
    end else if (clear) begin
      phase    <= '0;
      half_cnt <= '0;
      shreg    <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
    end else if (en) begin
      if (half_tick) begin
        phase    <= '0;
        half_cnt <= byte_done ? 4'd0 : half_cnt + 4'd1;
        sck      <= ~sck;
        // Falling edge (sck currently high) presents the next bit, except after bit 0
        if (sck && !byte_done) begin
          shreg <= {shreg[6:0], 1'b0};
          mosi  <= shreg[6];
        end
      end else begin
        phase <= phase + 8'd1;
      end
    end
  end

endmodule

// File: rtl/rgbw_spi_master.sv
// RGBW frame transmitter: latches a 7-byte payload on start and sends it over SPI mode 0
// with cs framing, inter-byte gaps and a done pulse.
// Optional build macro RGBW_TX_CHECKSUM_EN adds an 8th byte = XOR of the payload bytes.
module rgbw_spi_master
  import rgbw_pkg::*;
#(
  parameter int SCK_HALF = 4,
  parameter int BYTE_GAP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] mode,
  input  logic [7:0] lint,
  input  logic [7:0] color_idx,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic [7:0] white,
  output logic       ready,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  output logic       cs
);

  state_t      state;
  logic [15:0] tmr;
  logic [2:0]  byte_idx;
  logic [2:0]  next_idx;
  logic [7:0]  shadow [PAYLOAD_LEN];
  logic [7:0]  tx_data;
  logic        setup_end, gap_end, fin_end;
  logic        tx_load, tx_done;

  assign setup_end = (state == SETUP)  && (tmr == 16'(SCK_HALF - 1));
  assign gap_end   = (state == GAP)    && (tmr == 16'(BYTE_GAP - 1));
  assign fin_end   = (state == FINISH) && (tmr == 16'(SCK_HALF - 1));
  assign tx_load   = ((state == IDLE) && start) || gap_end;
  assign next_idx  = byte_idx + 3'd1;

`ifdef RGBW_TX_CHECKSUM_EN
  logic [7:0] csum;

  // XOR of the latched payload bytes, sent as the final frame byte
  always_comb begin
    csum = '0;
    for (int i = 0; i < PAYLOAD_LEN; i++) csum = csum ^ shadow[i];
  end
`endif

  // Byte handed to the shifter: live byte 0 on accept, otherwise the next shadow byte
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tx_data = mode;
    if (state != IDLE) begin
      tx_data = shadow[next_idx];
`ifdef RGBW_TX_CHECKSUM_EN
      if (next_idx == BYTE_CSUM) tx_data = csum;
`endif
    end
  end

  spi_byte_tx #(
    .SCK_HALF(SCK_HALF)
  ) u_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .load     (tx_load),
    .clear    (fin_end),
    .en       (state == SHIFT),
    .data     (tx_data),
    .byte_done(tx_done),
    .sck      (sck),
    .mosi     (mosi)
  );

  // Frame FSM with registered cs / ready / done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tmr      <= '0;
      byte_idx <= '0;
      cs       <= 1'b1;
      ready    <= 1'b1;
      done     <= 1'b0;
      // NOTE: the shadow frame is a small register file, so it is cleared on reset.
      for (int i = 0; i < PAYLOAD_LEN; i++) shadow[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow[BYTE_MODE]  <= mode;
            shadow[BYTE_LINT]  <= lint;
            shadow[BYTE_COLOR] <= color_idx;
            shadow[BYTE_RED]   <= red;
            shadow[BYTE_GREEN] <= green;
            shadow[BYTE_BLUE]  <= blue;
            shadow[BYTE_WHITE] <= white;
            state    <= SETUP;
            tmr      <= '0;
            byte_idx <= '0;
            cs       <= 1'b0;
            ready    <= 1'b0;
          end
        end
        SETUP: begin
          if (setup_end) begin
            state <= SHIFT;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        SHIFT: begin
          if (tx_done) begin
            tmr   <= '0;
            state <= (byte_idx == 3'(FRAME_LEN - 1)) ? FINISH : GAP;
          end
        end
        GAP: begin
          if (gap_end) begin
            state    <= SHIFT;
            tmr      <= '0;
            byte_idx <= next_idx;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        FINISH: begin
          if (fin_end) begin
            state    <= IDLE;
            tmr      <= '0;
            byte_idx <= '0;
            cs       <= 1'b1;
            ready    <= 1'b1;
            done     <= 1'b1;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
